// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int NUM_REQ             = 2;
  localparam int DEFAULT_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational 2-way picker: round-robin on a tie by default,
// fixed priority to requester 0 when ARB_FIXED_PRIO_EN is defined.
module rr_picker (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10: winner = 1'b1;
`ifdef ARB_FIXED_PRIO_EN
      2'b11: winner = 1'b0;
`else
      // On a tie, the requester that did not win last time goes first
      2'b11: winner = ~last_grant;
`endif
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes block reads and write-backs from two caches onto one memory port.
// Tie-break policy is selected in rr_picker via ARB_FIXED_PRIO_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 128,
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [NUM_REQ-1:0]    ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  grant_id,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t            state, state_next;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  last_grant, last_grant_next;
  logic                  is_write, is_write_next;
  logic [NUM_REQ-1:0]    ack_next;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic                  busy_next;
  logic                  grant_id_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next;
  logic                  mem_we_next;
  logic                  pick_valid;
  logic                  pick_winner;

  rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      is_write   <= 1'b0;
      ack        <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      last_grant <= last_grant_next;
      is_write   <= is_write_next;
      ack        <= ack_next;
      rdata      <= rdata_next;
      busy       <= busy_next;
      grant_id   <= grant_id_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      mem_we     <= mem_we_next;
    end
  end

  // is_write remembers the direction after mem_we has dropped, so the
  // final ACCESS cycle knows whether to capture read data.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    last_grant_next = last_grant;
    is_write_next   = is_write;
    ack_next        = '0;
    rdata_next      = rdata;
    busy_next       = busy;
    grant_id_next   = grant_id;
    mem_addr_next   = mem_addr;
    mem_wdata_next  = mem_wdata;
    mem_we_next     = mem_we;

    case (state)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_next     = ARB_ACCESS;
          grant_id_next  = pick_winner;
          is_write_next  = we[pick_winner];
          mem_we_next    = we[pick_winner];
          mem_addr_next  = pick_winner ? addr1 : addr0;
          mem_wdata_next = pick_winner ? wdata1 : wdata0;
          cnt_next       = CNT_W'(MEM_LATENCY - 1);
          busy_next      = 1'b1;
        end
      end
      ARB_ACCESS: begin
        mem_we_next = 1'b0;
        if (cnt == '0) begin
          if (!is_write) begin
            rdata_next = mem_rdata;
          end
          ack_next   = grant_id ? 2'b10 : 2'b01;
          state_next = ARB_DONE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ARB_DONE: begin
        last_grant_next = grant_id;
        busy_next       = 1'b0;
        state_next      = ARB_IDLE;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a posedge-write memory model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          grant_id;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:255];
  logic          preload_en;
  logic [7:0]    preload_idx;
  logic [DW-1:0] preload_data;

  int total = 0;
  int bad   = 0;

  localparam logic [DW-1:0] PAT_A5  = {16{8'hA5}};
  localparam logic [DW-1:0] PAT_WR  = 128'h1234;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .grant_id  (grant_id),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Memory indexed by block address bits [11:4]; preload port used during reset
  always @(posedge clk) begin
    if (preload_en) mem[preload_idx] <= preload_data;
    else if (mem_we) mem[mem_addr[11:4]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[11:4]];

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack"},       DW'(ack),       '0);
    checkOutput({tag, "_rdata"},     rdata,          '0);
    checkOutput({tag, "_busy"},      DW'(busy),      '0);
    checkOutput({tag, "_grant"},     DW'(grant_id),  '0);
    checkOutput({tag, "_mem_addr"},  DW'(mem_addr),  '0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata,      '0);
    checkOutput({tag, "_mem_we"},    DW'(mem_we),    '0);
  endtask

  // One transaction of 4 ACCESS cycles plus DONE; first tick is the first ACCESS cycle
  task automatic runTxn(input string tag, input logic exp_grant, input logic [1:0] exp_ack,
                        input logic [DW-1:0] exp_rdata, input logic exp_we);
    tick();
    checkOutput({tag, "_grant"}, DW'(grant_id), DW'(exp_grant));
    checkOutput({tag, "_we1"},   DW'(mem_we),   DW'(exp_we));
    checkOutput({tag, "_busy1"}, DW'(busy),     1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      checkOutput({tag, "_ack_early"}, DW'(ack),    '0);
      checkOutput({tag, "_we_later"},  DW'(mem_we), '0);
      checkOutput({tag, "_busy"},      DW'(busy),   1);
    end
    tick();
    checkOutput({tag, "_ack"},       DW'(ack),  DW'(exp_ack));
    checkOutput({tag, "_rdata"},     rdata,     exp_rdata);
    checkOutput({tag, "_busy_done"}, DW'(busy), 1);
  endtask

  initial begin
    logic exp_order [4];
`ifdef ARB_FIXED_PRIO_EN
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    preload_en = 1'b1; preload_idx = 8'h23; preload_data = PAT_A5;
    tick();
    preload_idx = 8'h56; preload_data = '0;
    tick();
    preload_idx = 8'h00;
    tick();
    preload_en = 1'b0;
    checkResetState("reset");
    reset = 1'b0;
    tick();
    checkResetState("idle_after_reset");

    $display("[TB] single read");
    applyStimulus(2'b01, 2'b00, 32'h0000_1230, '0, '0, '0);
    runTxn("read0", 1'b0, 2'b01, PAT_A5, 1'b0);
    checkOutput("read0_addr", DW'(mem_addr), DW'(32'h0000_1230));
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    checkOutput("read0_idle_busy", DW'(busy), '0);
    checkOutput("read0_idle_ack",  DW'(ack),  '0);

    $display("[TB] single write");
    applyStimulus(2'b10, 2'b10, '0, 32'h0000_4560, '0, PAT_WR);
    tick();
    checkOutput("write1_mem_we",    DW'(mem_we),    1);
    checkOutput("write1_mem_addr",  DW'(mem_addr),  DW'(32'h0000_4560));
    checkOutput("write1_mem_wdata", mem_wdata,      PAT_WR);
    checkOutput("write1_grant",     DW'(grant_id),  1);
    applyStimulus(2'b10, 2'b10, '0, 32'h0000_9990, '0, 128'hDEAD);
    tick();
    checkOutput("write1_we_drop",   DW'(mem_we),    '0);
    checkOutput("write1_wdata_held", mem_wdata,     PAT_WR);
    checkOutput("write1_addr_held", DW'(mem_addr),  DW'(32'h0000_4560));
    tick();
    tick();
    checkOutput("write1_ack_early", DW'(ack), '0);
    tick();
    checkOutput("write1_ack",       DW'(ack), 2'b10);
    checkOutput("write1_rdata_kept", rdata,   PAT_A5);
    checkOutput("write1_mem_model", mem[8'h56], PAT_WR);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    checkOutput("write1_idle_busy", DW'(busy), '0);

    $display("[TB] contention from reset");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(2'b11, 2'b00, 32'h0000_1230, 32'h0000_4560, '0, '0);
    for (int k = 0; k < 4; k++) begin
      runTxn($sformatf("cont%0d", k), exp_order[k], exp_order[k] ? 2'b10 : 2'b01,
             exp_order[k] ? PAT_WR : PAT_A5, 1'b0);
      if (k == 3) applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
      tick();
      checkOutput($sformatf("cont%0d_idle_busy", k), DW'(busy), '0);
    end

    $display("[TB] stale request");
    applyStimulus(2'b01, 2'b00, 32'h0000_1230, '0, '0, '0);
    runTxn("stale_a", 1'b0, 2'b01, PAT_A5, 1'b0);
    tick();
    checkOutput("stale_idle_busy", DW'(busy), '0);
    checkOutput("stale_idle_ack",  DW'(ack),  '0);
    runTxn("stale_b", 1'b0, 2'b01, PAT_A5, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    checkOutput("stale_end_busy", DW'(busy), '0);

    $display("[TB] reset mid-transaction");
    applyStimulus(2'b01, 2'b00, 32'h0000_1230, '0, '0, '0);
    tick();
    tick();
    checkOutput("midrst_busy_before", DW'(busy), 1);
    reset = 1'b1;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    checkResetState("midrst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("midrst_no_ack", DW'(ack), '0);
    end
    applyStimulus(2'b10, 2'b00, '0, 32'h0000_4560, '0, '0);
    runTxn("after_rst", 1'b1, 2'b10, PAT_WR, 1'b0);
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    checkOutput("after_rst_idle", DW'(busy), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
